// File: rtl/display_scan_pkg.sv
// display_scan_pkg: shared anode codes, digit indices and anode-select helper for the display scanner.
package display_scan_pkg;
    localparam logic [3:0] AN_OFF = 4'b1111;
    localparam logic [3:0] AN_D0  = 4'b1110;
    localparam logic [3:0] AN_D1  = 4'b1101;
    localparam logic [3:0] AN_D2  = 4'b1011;
    localparam logic [3:0] AN_D3  = 4'b0111;

    typedef enum logic [1:0] {
        DIG_SEC_ONES = 2'd0,
        DIG_SEC_TENS = 2'd1,
        DIG_MIN_ONES = 2'd2,
        DIG_MIN_TENS = 2'd3
    } dig_e;

    function automatic logic [3:0] an_sel(input logic [1:0] idx);
        return idx == DIG_SEC_ONES ? AN_D0 :
               idx == DIG_SEC_TENS ? AN_D1 :
               idx == DIG_MIN_ONES ? AN_D2 : AN_D3;
    endfunction
endpackage

// File: rtl/display_scan_if.sv
// display_scan_if: digit/mode inputs and scan outputs between the stopwatch core and the display.
interface display_scan_if;
    logic [15:0] digits_in;
    logic        adjust_en;
    logic        adjust_sel;
    logic        blank_lead_zero;
    logic [3:0]  display_state;
    logic [3:0]  anode;
    logic [1:0]  digit_idx;
    logic        frame_start;

    modport master(
        output digits_in, adjust_en, adjust_sel, blank_lead_zero,
        input  display_state, anode, digit_idx, frame_start
    );
    modport slave(
        input  digits_in, adjust_en, adjust_sel, blank_lead_zero,
        output display_state, anode, digit_idx, frame_start
    );
endinterface

// File: rtl/display_scan_prescaler.sv
// scan_prescaler: free-running divider, one-cycle tick every DIV clocks.
module scan_prescaler #(
    parameter int DIV = 100000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);
    localparam int W = DIV > 1 ? $clog2(DIV) : 1;
    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        tick  = cnt_q == W'(DIV - 1);
        cnt_d = tick ? '0 : cnt_q + W'(1);
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
endmodule

// File: rtl/display_scan.sv
// display_scan: multiplexes MM:SS BCD digits onto a 4-digit display with
// per-frame snapshots, adjust-pair blinking and leading-zero blanking.
module display_scan
    import display_scan_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int BLINK_TICKS = 250
) (
    input logic           clk,
    input logic           rst_n,
    display_scan_if.slave bus
);
    localparam int BW = BLINK_TICKS > 1 ? $clog2(BLINK_TICKS) : 1;

    logic          tick, wrap, blank, blink_wrap;
    logic [1:0]    idx_q, idx_d;
    logic [15:0]   shadow_q, shadow_d, src;
    logic [3:0]    nib, ds_q, ds_d, an_q, an_d;
    logic          fs_q, fs_d, phase_q, phase_d;
    logic [BW-1:0] bcnt_q, bcnt_d;

    scan_prescaler #(.DIV(REFRESH_DIV)) u_pre (.clk(clk), .rst_n(rst_n), .tick(tick));

    // On the wrap to digit 0 the value being captured is shown directly, so the
    // new frame is coherent from its first slot.
    always_comb begin
        wrap       = idx_q == DIG_MIN_TENS;
        idx_d      = tick ? idx_q + 2'd1 : idx_q;
        src        = wrap ? bus.digits_in : shadow_q;
        nib        = src[{idx_d, 2'b00} +: 4];
        shadow_d   = tick && wrap ? bus.digits_in : shadow_q;
        fs_d       = tick && wrap;
        blank      = (bus.adjust_en && phase_q && idx_d[1] != bus.adjust_sel) ||
                     (bus.blank_lead_zero && idx_d == DIG_MIN_TENS && src[15:12] == 4'd0);
        ds_d       = tick ? (nib > 4'd9 ? 4'd0 : nib) : ds_q;
        an_d       = tick ? (blank ? AN_OFF : an_sel(idx_d)) : an_q;
        blink_wrap = bcnt_q == BW'(BLINK_TICKS - 1);
        bcnt_d     = !tick ? bcnt_q : !bus.adjust_en || blink_wrap ? '0 : bcnt_q + BW'(1);
        phase_d    = !tick ? phase_q : bus.adjust_en && (phase_q ^ blink_wrap);
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            idx_q    <= DIG_MIN_TENS;
            shadow_q <= '0;
            ds_q     <= '0;
            an_q     <= AN_OFF;
            fs_q     <= 1'b0;
            phase_q  <= 1'b0;
            bcnt_q   <= '0;
        end else begin
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            ds_q     <= ds_d;
            an_q     <= an_d;
            fs_q     <= fs_d;
            phase_q  <= phase_d;
            bcnt_q   <= bcnt_d;
        end

    assign bus.display_state = ds_q;
    assign bus.anode         = an_q;
    assign bus.digit_idx     = idx_q;
    assign bus.frame_start   = fs_q;
endmodule
